// File: rtl/counter_sequencer_if.sv
// rtl/counter_sequencer_if.sv - control, status and counter-datapath signals of the counter sequencer
interface counter_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int LAP_W = 8
);
  logic             start;
  logic             stop;
  logic             pause;
  logic             resume;
  logic             up;
  logic [WIDTH-1:0] limit;
  logic [LAP_W-1:0] laps;
  logic [WIDTH-1:0] ctr_count;
  logic             ctr_en;
  logic             ctr_up;
  logic             ctr_load;
  logic [WIDTH-1:0] ctr_load_val;
  logic             ctr_clr;
  logic             busy;
  logic             done;
  logic [LAP_W-1:0] lap_count;

  modport master (
    input  start, stop, pause, resume, up, limit, laps, ctr_count,
    output ctr_en, ctr_up, ctr_load, ctr_load_val, ctr_clr, busy, done, lap_count
  );

  modport slave (
    output start, stop, pause, resume, up, limit, laps, ctr_count,
    input  ctr_en, ctr_up, ctr_load, ctr_load_val, ctr_clr, busy, done, lap_count
  );
endinterface

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - lap-counting FSM driving an external up/down counter datapath
module counter_sequencer #(
  parameter int WIDTH = 4,
  parameter int LAP_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  counter_sequencer_if.master   bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] RUN    = 3'd2;
  localparam logic [2:0] PAUSED = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]       state;
  logic             up_q;
  logic [WIDTH-1:0] limit_q;
  logic [LAP_W-1:0] laps_q;
  logic [LAP_W-1:0] lap_q;

  logic [WIDTH-1:0] s_val;
  logic [WIDTH-1:0] e_val;
  logic             at_end;
  logic             last_lap;

  assign s_val    = up_q ? '0 : limit_q;
  assign e_val    = up_q ? limit_q : '0;
  assign at_end   = (bus.ctr_count == e_val);
  assign last_lap = ((lap_q + LAP_W'(1)) == laps_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      up_q    <= 1'b0;
      limit_q <= '0;
      laps_q  <= '0;
      lap_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            up_q    <= bus.up;
            limit_q <= bus.limit;
            laps_q  <= bus.laps;
            lap_q   <= '0;
            state   <= (bus.laps == '0) ? DONE : LOAD;
          end
        end
        LOAD: state <= RUN;
        RUN: begin
          if (bus.stop) begin
            state <= IDLE;
          end else if (bus.pause) begin
            state <= PAUSED;
          end else if (at_end) begin
            lap_q <= lap_q + LAP_W'(1);
            if (last_lap) begin
              state <= DONE;
            end
          end
        end
        PAUSED: begin
          if (bus.stop) begin
            state <= IDLE;
          end else if (bus.resume) begin
            state <= RUN;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Counter controls are decoded combinationally so the datapath acts on the same edge the FSM advances.
  always_comb begin
    bus.ctr_en   = 1'b0;
    bus.ctr_load = 1'b0;
    bus.ctr_clr  = 1'b0;
    case (state)
      LOAD: bus.ctr_load = 1'b1;
      RUN: begin
        if (bus.stop) begin
          bus.ctr_clr = 1'b1;
        end else if (!bus.pause) begin
          if (at_end) begin
            bus.ctr_load = !last_lap;
          end else begin
            bus.ctr_en = 1'b1;
          end
        end
      end
      PAUSED:  bus.ctr_clr = bus.stop;
      default: ;
    endcase
  end

  assign bus.busy         = (state != IDLE);
  assign bus.done         = (state == DONE);
  assign bus.ctr_up       = bus.busy & up_q;
  assign bus.ctr_load_val = bus.ctr_load ? s_val : '0;
  assign bus.lap_count    = lap_q;
endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - randomized self-checking bench for counter_sequencer with a counter datapath model
module tb_counter_sequencer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   tb_cycle;

  counter_sequencer_if #(.WIDTH(4), .LAP_W(8)) bus ();

  counter_sequencer #(.WIDTH(4), .LAP_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) tb_cycle <= tb_cycle + 1;

  // External counter datapath as the sequencer expects it to behave.
  always @(posedge clk or posedge rst) begin
    if (rst) bus.ctr_count <= 4'd0;
    else if (bus.ctr_clr) bus.ctr_count <= 4'd0;
    else if (bus.ctr_load) bus.ctr_count <= bus.ctr_load_val;
    else if (bus.ctr_en) bus.ctr_count <= bus.ctr_up ? bus.ctr_count + 4'd1 : bus.ctr_count - 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive_junk(input bit junk);
    if (junk) begin
      bus.start = 1'($urandom);
      bus.up    = 1'($urandom);
      bus.limit = 4'($urandom);
      bus.laps  = 8'($urandom);
    end else begin
      bus.start = 1'b0;
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_en"}, bus.ctr_en, 0);
    chk({tag, "_load"}, bus.ctr_load, 0);
    chk({tag, "_clr"}, bus.ctr_clr, 0);
  endtask

  // Expected behaviour is derived from run progress p: lap = p / (lim+1), position = p % (lim+1).
  task automatic run_seq(input logic u, input int lim, input int nl, input int pause_p,
                         input int pause_len, input int stop_p, input bit junk);
    int  len, p, stall, prem, t0, lap, off, exp_cnt;
    bit  paused, pdone;
    len = lim + 1; p = 0; stall = 0; prem = 0; paused = 0; pdone = 0;

    @(posedge clk); #1;
    bus.start = 1'b1; bus.up = u; bus.limit = 4'(lim); bus.laps = 8'(nl);
    bus.stop = 1'b0; bus.pause = 1'b0; bus.resume = 1'b0;
    t0 = tb_cycle;
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);

    if (nl == 0) begin
      @(posedge clk); #1; drive_junk(junk);
      @(negedge clk);
      chk("zero_done", bus.done, 1);
      chk_quiet("zero");
      chk("zero_lap", bus.lap_count, 0);
      chk("zero_latency", tb_cycle - t0, 1);
    end else begin
      @(posedge clk); #1; drive_junk(junk);
      @(negedge clk);
      chk("load", bus.ctr_load, 1);
      chk("load_val", bus.ctr_load_val, u ? 0 : lim);
      chk("load_up", bus.ctr_up, u);
      chk("load_busy", bus.busy, 1);
      chk("load_en", bus.ctr_en, 0);

      while (1) begin
        @(posedge clk); #1; drive_junk(junk);
        bus.stop = 1'b0; bus.pause = 1'b0;
        bus.resume = junk ? 1'($urandom) : 1'b0;
        off = p % len;
        lap = p / len;
        exp_cnt = u ? off : lim - off;
        if (paused) begin
          bus.pause  = junk ? 1'($urandom) : 1'b0;
          bus.resume = (prem == 1);
          stall++;
          @(negedge clk);
          chk_quiet("paused");
          chk("paused_busy", bus.busy, 1);
          chk("paused_count", bus.ctr_count, exp_cnt);
          prem--;
          if (prem == 0) paused = 0;
          continue;
        end
        if (p == stop_p) begin
          bus.stop = 1'b1;
          @(negedge clk);
          chk("stop_clr", bus.ctr_clr, 1);
          chk("stop_en", bus.ctr_en, 0);
          chk("stop_load", bus.ctr_load, 0);
          chk("stop_lap", bus.lap_count, lap);
          @(posedge clk); #1;
          bus.stop = 1'b0; bus.start = 1'b0; bus.resume = 1'b0;
          @(negedge clk);
          chk("stop_busy", bus.busy, 0);
          chk("stop_done", bus.done, 0);
          chk("stop_clr_pulse", bus.ctr_clr, 0);
          chk("stop_lap_held", bus.lap_count, lap);
          return;
        end
        if (p == pause_p && !pdone) begin
          bus.pause = 1'b1; bus.resume = 1'b0;
          pdone = 1; paused = 1; prem = pause_len - 1; stall++;
          @(negedge clk);
          chk_quiet("pause");
          chk("pause_count", bus.ctr_count, exp_cnt);
          continue;
        end
        @(negedge clk);
        chk("run_count", bus.ctr_count, exp_cnt);
        chk("run_en", bus.ctr_en, off != lim);
        chk("run_load", bus.ctr_load, (off == lim) && (lap + 1 < nl));
        chk("run_clr", bus.ctr_clr, 0);
        chk("run_lap", bus.lap_count, lap);
        chk("run_up", bus.ctr_up, u);
        chk("run_done", bus.done, 0);
        if (bus.ctr_load) chk("run_load_val", bus.ctr_load_val, u ? 0 : lim);
        if (off == lim && lap + 1 == nl) break;
        p++;
      end

      @(posedge clk); #1; drive_junk(junk);
      bus.stop = 1'b0; bus.pause = 1'b0; bus.resume = 1'b0;
      @(negedge clk);
      chk("done", bus.done, 1);
      chk("done_busy", bus.busy, 1);
      chk_quiet("done");
      chk("done_lap", bus.lap_count, nl);
      chk("done_latency", tb_cycle - t0, 2 + nl * len + stall);
    end

    @(posedge clk); #1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0; bus.resume = 1'b0;
    @(negedge clk);
    chk("end_busy", bus.busy, 0);
    chk("end_done", bus.done, 0);
    chk("end_lap", bus.lap_count, nl);
  endtask

  initial begin
    checks = 0; errors = 0; tb_cycle = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0; bus.resume = 1'b0;
    bus.up = 1'b0; bus.limit = 4'd0; bus.laps = 8'd0;
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk_quiet("rst");
    chk("rst_up", bus.ctr_up, 0);
    chk("rst_load_val", bus.ctr_load_val, 0);
    chk("rst_lap", bus.lap_count, 0);
    @(posedge clk); #1 rst = 1'b0;

    run_seq(1'b1, 3, 2, -1, 0, -1, 1'b0);
    run_seq(1'b0, 5, 1, -1, 0, -1, 1'b0);
    run_seq(1'b1, 3, 0, -1, 0, -1, 1'b0);
    run_seq(1'b1, 3, 1, 2, 5, -1, 1'b0);
    run_seq(1'b1, 7, 3, -1, 0, 11, 1'b1);
    run_seq(1'b1, 0, 3, -1, 0, -1, 1'b0);
    run_seq(1'b0, 0, 2, 1, 2, -1, 1'b1);
    run_seq(1'b0, 15, 1, -1, 0, -1, 1'b1);

    // Asynchronous reset in the middle of the second lap.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.up = 1'b1; bus.limit = 4'd1; bus.laps = 8'd4;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_lap", bus.lap_count, 1);
    chk("pre_rst_en", bus.ctr_en, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_en", bus.ctr_en, 0);
    chk("mid_rst_lap", bus.lap_count, 0);
    @(posedge clk); #1 rst = 1'b0;
    run_seq(1'b1, 2, 2, -1, 0, -1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      int lim, nl, pp, pl, sp;
      logic u;
      u   = 1'($urandom);
      lim = ($urandom_range(0, 3) == 0) ? 15 : $urandom_range(0, 6);
      nl  = $urandom_range(0, 4);
      pp  = -1; pl = 2; sp = -1;
      if (nl > 0 && $urandom_range(0, 1) == 1) begin
        pp = $urandom_range(0, nl * (lim + 1) - 1);
        pl = $urandom_range(2, 5);
      end
      if (nl > 0 && $urandom_range(0, 3) == 0) sp = $urandom_range(0, nl * (lim + 1) - 1);
      run_seq(u, lim, nl, pp, pl, sp, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
